// File: rtl/wb_arb_pkg.sv
// Shared constants and helpers for the three-master Wishbone round-robin arbiter.
package wb_arb_pkg;

    localparam int unsigned NUM_MASTERS     = 3;
    localparam int unsigned M0              = 0;
    localparam int unsigned M1              = 1;
    localparam int unsigned M2              = 2;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_MASTERS-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating-priority picker: searches last+1, last+2, last (mod 3) and returns the first requester one-hot.
module wb_rr_pick
    import wb_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [1:0]             last_i,
    output logic [NUM_MASTERS-1:0] pick_o
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            idx = 2'((32'(last_i) + i) % NUM_MASTERS);
            if (!found && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Three-master Wishbone round-robin arbiter onto one shared slave, with a stalled-strobe watchdog.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    input  logic [31:0] m2_adr_i,
    input  logic [31:0] m2_dat_i,
    input  logic [3:0]  m2_sel_i,
    input  logic        m2_we_i,
    input  logic        m2_cyc_i,
    input  logic        m2_stb_i,
    output logic [31:0] m2_dat_o,
    output logic        m2_ack_o,
    output logic        m2_err_o,

    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    output logic [2:0]  grant_o,
    output logic        timeout_o
);

    // TIMEOUT=0 would give a zero-width counter; keep one bit and hold it at zero.
    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    logic [NUM_MASTERS-1:0] cyc;
    logic [NUM_MASTERS-1:0] stb;
    logic [NUM_MASTERS-1:0] we;
    logic [31:0]            adr [NUM_MASTERS];
    logic [31:0]            wdat[NUM_MASTERS];
    logic [3:0]             sel [NUM_MASTERS];

    assign cyc = {m2_cyc_i, m1_cyc_i, m0_cyc_i};
    assign stb = {m2_stb_i, m1_stb_i, m0_stb_i};
    assign we  = {m2_we_i,  m1_we_i,  m0_we_i};

    assign adr[M0]  = m0_adr_i;
    assign adr[M1]  = m1_adr_i;
    assign adr[M2]  = m2_adr_i;
    assign wdat[M0] = m0_dat_i;
    assign wdat[M1] = m1_dat_i;
    assign wdat[M2] = m2_dat_i;
    assign sel[M0]  = m0_sel_i;
    assign sel[M1]  = m1_sel_i;
    assign sel[M2]  = m2_sel_i;

    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [1:0]             ptr_q, ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] pick;
    logic                   g_cyc;
    logic                   g_stb;
    logic                   stall;
    logic                   tmo;

    wb_rr_pick u_pick (
        .req_i  (cyc),
        .last_i (ptr_q),
        .pick_o (pick)
    );

    always_comb begin
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = '0;
        g_cyc   = |(grant_q & cyc);
        g_stb   = |(grant_q & stb);
        stall   = g_stb && !s_ack_i;
        tmo     = 1'b0;

        if (grant_q == '0 || !g_cyc) begin
            grant_d = pick;
            if (pick != '0) ptr_d = onehot_to_idx(pick);
        end

        // Ack on the would-be timeout cycle wins because stall already excludes s_ack_i.
        if (TIMEOUT != 0) begin
            tmo = stall && (cnt_q == CW'(TIMEOUT - 1));
            if (stall && !tmo && grant_d == grant_q) cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q <= '0;
            ptr_q   <= 2'(M2);
            cnt_q   <= '0;
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                s_adr_o = adr[i];
                s_dat_o = wdat[i];
                s_sel_o = sel[i];
                s_we_o  = we[i];
            end
        end
    end

    assign s_cyc_o   = g_cyc && !tmo;
    assign s_stb_o   = g_stb && !tmo;
    assign grant_o   = grant_q;
    assign timeout_o = tmo;

    assign m0_dat_o  = s_dat_i;
    assign m1_dat_o  = s_dat_i;
    assign m2_dat_o  = s_dat_i;
    assign m0_ack_o  = grant_q[M0] && s_ack_i;
    assign m1_ack_o  = grant_q[M1] && s_ack_i;
    assign m2_ack_o  = grant_q[M2] && s_ack_i;
    assign m0_err_o  = grant_q[M0] && tmo;
    assign m1_err_o  = grant_q[M1] && tmo;
    assign m2_err_o  = grant_q[M2] && tmo;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Randomized scoreboard bench for wb_rr_arbiter against an integer-level round-robin/watchdog model.
module tb_wb_rr_arbiter;

    localparam int unsigned TO   = 16;
    localparam int          NCYC = 3000;

    typedef struct {
        logic [2:0]  grant;
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [2:0]  ack;
        logic [2:0]  err;
        logic        tmo;
        logic [31:0] rdat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_adr[3];
    logic [31:0] m_dat[3];
    logic [3:0]  m_sel[3];
    logic        m_we [3];
    logic        m_cyc[3];
    logic        m_stb[3];
    logic [31:0] s_dat;
    logic        s_ack;

    logic [31:0] m0_dat_o, m1_dat_o, m2_dat_o;
    logic        m0_ack_o, m1_ack_o, m2_ack_o;
    logic        m0_err_o, m1_err_o, m2_err_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]  grant_o;
    logic        timeout_o;

    int checks   = 0;
    int failures = 0;

    // Reference model state: owner index (-1 = none), last granted index, stalled-cycle count.
    int owner    = -1;
    int last     = 2;
    int cnt      = 0;
    bit prev_tmo = 1'b0;
    int n_tmo    = 0;
    int n_coinc  = 0;
    int n_move   = 0;

    exp_t expq[$];

    always #5 clk = ~clk;

    wb_rr_arbiter #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_adr_i  (m_adr[0]), .m0_dat_i (m_dat[0]), .m0_sel_i (m_sel[0]),
        .m0_we_i   (m_we[0]),  .m0_cyc_i (m_cyc[0]), .m0_stb_i (m_stb[0]),
        .m0_dat_o  (m0_dat_o), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
        .m1_adr_i  (m_adr[1]), .m1_dat_i (m_dat[1]), .m1_sel_i (m_sel[1]),
        .m1_we_i   (m_we[1]),  .m1_cyc_i (m_cyc[1]), .m1_stb_i (m_stb[1]),
        .m1_dat_o  (m1_dat_o), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
        .m2_adr_i  (m_adr[2]), .m2_dat_i (m_dat[2]), .m2_sel_i (m_sel[2]),
        .m2_we_i   (m_we[2]),  .m2_cyc_i (m_cyc[2]), .m2_stb_i (m_stb[2]),
        .m2_dat_o  (m2_dat_o), .m2_ack_o (m2_ack_o), .m2_err_o (m2_err_o),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_sel_o   (s_sel_o),
        .s_we_o    (s_we_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_dat_i   (s_dat),
        .s_ack_i   (s_ack),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        owner    = -1;
        last     = 2;
        cnt      = 0;
        prev_tmo = 1'b0;
    endtask

    // Clock-edge update, using the inputs that were stable before the edge.
    task automatic model_advance();
        int nxt;
        if (!rst) begin
            model_reset();
            return;
        end
        nxt = owner;
        if (owner < 0 || !m_cyc[owner]) begin
            nxt = -1;
            for (int k = 1; k <= 3; k++) begin
                int c;
                c = (last + k) % 3;
                if (nxt < 0 && m_cyc[c]) nxt = c;
            end
            if (nxt >= 0) last = nxt;
            if (owner >= 0 && nxt >= 0 && nxt != owner) n_move++;
        end
        if (nxt == owner && owner >= 0 && m_stb[owner] && !s_ack && !prev_tmo) cnt++;
        else cnt = 0;
        owner = nxt;
    endtask

    task automatic push_expected();
        exp_t e;
        bit   t;
        t = (owner >= 0) && m_stb[owner] && !s_ack && (cnt == int'(TO) - 1);
        if ((owner >= 0) && m_stb[owner] && s_ack && (cnt == int'(TO) - 1)) n_coinc++;
        e.grant = (owner < 0) ? 3'b000 : 3'(1 << owner);
        e.cyc   = (owner >= 0) && m_cyc[owner] && !t;
        e.stb   = (owner >= 0) && m_stb[owner] && !t;
        e.we    = (owner >= 0) ? m_we[owner]  : 1'b0;
        e.adr   = (owner >= 0) ? m_adr[owner] : 32'h0;
        e.wdat  = (owner >= 0) ? m_dat[owner] : 32'h0;
        e.sel   = (owner >= 0) ? m_sel[owner] : 4'h0;
        e.ack   = (owner >= 0 && s_ack) ? 3'(1 << owner) : 3'b000;
        e.err   = t ? 3'(1 << owner) : 3'b000;
        e.tmo   = t;
        e.rdat  = s_dat;
        prev_tmo = t;
        if (t) n_tmo++;
        expq.push_back(e);
    endtask

    task automatic drive(input int n);
        rst = !(n < 3 || (n >= 1500 && n < 1502) || (n >= 8 && $urandom_range(299) == 0));
        s_dat = $urandom;
        s_ack = 1'b0;
        if (n < 8) begin
            // Lone m1 read: request at n=3, grant at n=4, slave ack with data at n=5.
            for (int m = 0; m < 3; m++) begin
                m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
                m_adr[m] = 32'h0; m_dat[m] = 32'h0; m_sel[m] = 4'h0;
            end
            if (n >= 3 && n <= 5) begin
                m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
                m_adr[1] = 32'h0000_1000; m_sel[1] = 4'hF;
            end
            if (n == 5) begin
                s_ack = 1'b1;
                s_dat = 32'hCAFE_0001;
            end
            return;
        end
        for (int m = 0; m < 3; m++) begin
            if (m_cyc[m]) begin
                if ($urandom_range((n >= 1200 && n < 2400) ? 39 : 7) == 0) m_cyc[m] = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                m_cyc[m] = 1'b1;
            end
            m_stb[m] = m_cyc[m] && ($urandom_range(7) != 0);
            m_adr[m] = $urandom;
            m_dat[m] = $urandom;
            m_sel[m] = 4'($urandom_range(15));
            m_we[m]  = 1'($urandom_range(1));
        end
        if (n < 1200) begin
            s_ack = ($urandom_range(2) == 0);
        end else if (n < 2400) begin
            // Slave stalls; half of the would-be timeout cycles get a last-moment ack.
            s_ack = (owner >= 0) && (cnt == int'(TO) - 1) && ($urandom_range(1) == 0);
        end else begin
            s_ack = ($urandom_range(1) == 0);
        end
    endtask

    initial begin
        rst = 1'b0;
        s_ack = 1'b0;
        s_dat = 32'h0;
        for (int m = 0; m < 3; m++) begin
            m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
            m_adr[m] = 32'h0; m_dat[m] = 32'h0; m_sel[m] = 4'h0;
        end
        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            model_advance();
            #1;
            drive(n);
            if (!rst) model_reset();
            push_expected();
        end
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'h0);
        chk("cov_timeout_seen", 32'(n_tmo > 0), 32'h1);
        chk("cov_ack_at_timeout_seen", 32'(n_coinc > 0), 32'h1);
        chk("cov_grant_handoff_seen", 32'(n_move > 0), 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("grant_o",   32'(grant_o),   32'(e.grant));
                chk("s_cyc_o",   32'(s_cyc_o),   32'(e.cyc));
                chk("s_stb_o",   32'(s_stb_o),   32'(e.stb));
                chk("s_we_o",    32'(s_we_o),    32'(e.we));
                chk("s_adr_o",   s_adr_o,        e.adr);
                chk("s_dat_o",   s_dat_o,        e.wdat);
                chk("s_sel_o",   32'(s_sel_o),   32'(e.sel));
                chk("ack_o",     32'({m2_ack_o, m1_ack_o, m0_ack_o}), 32'(e.ack));
                chk("err_o",     32'({m2_err_o, m1_err_o, m0_err_o}), 32'(e.err));
                chk("timeout_o", 32'(timeout_o), 32'(e.tmo));
                chk("m0_dat_o",  m0_dat_o,       e.rdat);
                chk("m1_dat_o",  m1_dat_o,       e.rdat);
                chk("m2_dat_o",  m2_dat_o,       e.rdat);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit actual=expired required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 255, stalled-strobe cycles before a bus error (0 disables the watchdog).
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset (low = reset asserted).
REQ-004 mN_adr_i / mN_dat_i (N=0..2)  in  32 each  master address / write data.
REQ-005 mN_sel_i  in  4,  mN_we_i / mN_cyc_i / mN_stb_i  in  1 each  master byte selects / write enable / cycle / strobe.
REQ-006 mN_dat_o  out  32  read data; mN_ack_o / mN_err_o  out  1 each  master acknowledge / bus error.
REQ-007 s_adr_o / s_dat_o  out  32,  s_sel_o  out  4,  s_we_o / s_cyc_o / s_stb_o  out  1  shared-slave request.
REQ-008 s_dat_i  in  32,  s_ack_i  in  1  shared-slave read data and acknowledge.
REQ-009 grant_o  out  3  one-hot current grant, 000 = none; timeout_o  out  1  one-cycle watchdog pulse.

Function
REQ-010 Grant SHALL be a registered one-hot value; a request seen in cycle t is granted in cycle t+1 (1-cycle arbitration latency).
REQ-011 Re-arbitration SHALL occur only when grant is 000 or the granted master's cyc_i is low; otherwise grant holds regardless of other requests.
REQ-012 Selection SHALL be round-robin: after granting master k, priority order is k+1, k+2, k (mod 3); the pointer updates only when a new grant is issued.
REQ-013 When the granted master drops cyc_i while another requests, grant SHALL move directly to the next master in the following cycle (no extra idle state).
REQ-014 s_adr_o, s_dat_o, s_sel_o, s_we_o SHALL combinationally mirror the granted master; with no grant they drive 0.
REQ-015 s_cyc_o/s_stb_o SHALL equal the granted master's cyc_i/stb_i gated by the registered grant, so a dropped cyc_i deasserts s_cyc_o in the same cycle.
REQ-016 All mN_dat_o SHALL carry s_dat_i; only the granted master's ack_o SHALL follow s_ack_i, non-granted ack_o/err_o stay 0.
REQ-017 The watchdog counter SHALL increment each cycle the granted stb_i is high and s_ack_i low, and clear on s_ack_i, on stb_i low, or on a grant change.
REQ-018 On the cycle the counter reaches TIMEOUT: granted mN_err_o=1, timeout_o=1, s_cyc_o/s_stb_o forced 0, counter cleared; grant is retained until that master drops cyc_i.
REQ-019 If s_ack_i and the timeout coincide, ack SHALL win: ack_o=1, err_o=0, no timeout pulse.
REQ-020 Counter width SHALL be clog2(TIMEOUT+1) bits; with TIMEOUT=0 the counter, err_o and timeout_o SHALL be held at 0.

Reset
REQ-021 While rst is low: grant_o=000, pointer=2 (so m0 has top priority first), counter=0, timeout_o=0, all ack_o/err_o=0, s_cyc_o/s_stb_o/s_we_o=0, s_adr_o/s_dat_o/s_sel_o=0.
REQ-022 Reset asserted mid-transaction SHALL drop s_cyc_o immediately (asynchronously); no transaction resumes after release without a fresh arbitration.

Structure
REQ-023 Package wb_arb_pkg SHALL hold master index constants (M0=0, M1=1, M2=2), NUM_MASTERS=3 and the TIMEOUT default.
REQ-024 Rotating-priority selection SHALL be a combinational sub-module wb_rr_pick (inputs: 3-bit request, 2-bit last grant; output: one-hot pick).

Verification
REQ-025 m1 read alone: cyc/stb at t0 -> grant_o=010 and s_cyc_o=1 at t1; s_ack_i=1, s_dat_i=0xCAFE0001 at t2 -> m1_ack_o=1, m1_dat_o=0xCAFE0001 at t2.
REQ-026 All three request from reset release, each holding cyc 3 cycles after grant -> grant_o sequence 001,010,100,001.
REQ-027 TIMEOUT=16, m0 granted, slave never acks -> m0_err_o=1, timeout_o=1, s_stb_o=0 on 16th stalled cycle; grant held until m0 drops cyc.
REQ-028 m1 holds grant, m2 requesting, s_ack_i pulses -> only m1_ack_o=1; m1 drops cyc -> grant_o=100 next cycle.
REQ-029 rst low while m0 granted mid-access -> grant_o=000, s_cyc_o=0 immediately; after release with m0 and m1 requesting -> m0 granted first.
REQ-030 s_ack_i on the TIMEOUT-th stalled cycle -> ack_o=1, err_o=0, timeout_o=0.
